md5_digest_serializer: RTL



---
 rtl/md5_pkg.sv | 8 +
 rtl/md5_digest_serializer_if.sv | 13 +
 rtl/md5_hex_ascii.sv | 10 +
 rtl/md5_digest_serializer.sv | 82 ++++++++
 4 files changed

// File: rtl/md5_pkg.sv
// md5_pkg: shared state encoding and digest/ASCII constants for the MD5 path
package md5_pkg;
    typedef enum logic [1:0] {IDLE, SEND, CR, LF} state_e;
    localparam int DIGEST_BITS = 128;
    localparam int DIGEST_CHARS = 32;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
endpackage

// File: rtl/md5_digest_serializer_if.sv
// md5_digest_serializer_if: digest capture handshake and ASCII byte stream
interface md5_digest_serializer_if;
    logic         hash_valid;
    logic [0:127] hash;
    logic         hash_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready;
    logic         busy;
    logic         done;
    modport slave (input hash_valid, hash, tx_ready, output hash_ready, tx_data, tx_valid, busy, done);
    modport master (output hash_valid, hash, tx_ready, input hash_ready, tx_data, tx_valid, busy, done);
endinterface

// File: rtl/md5_hex_ascii.sv
// md5_hex_ascii: 4-bit nibble to ASCII hex character, case chosen by UPPERCASE
module md5_hex_ascii #(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    always_comb ascii = nibble < 4'd10 ? 8'h30 + {4'h0, nibble}
                                        : (UPPERCASE ? 8'h37 : 8'h57) + {4'h0, nibble};
endmodule

// File: rtl/md5_digest_serializer.sv
// md5_digest_serializer: latches a 128-bit digest and streams it as 32 hex chars;
// define MD5_SER_CRLF_EN to append "\r\n" after each digest.
module md5_digest_serializer
    import md5_pkg::*;
#(
    parameter bit UPPERCASE = 1'b0
) (
    input logic clk,
    input logic rst,
    md5_digest_serializer_if.slave bus
);
    state_e                 state_q, state_d;
    logic [0:DIGEST_BITS-1] hash_q, hash_d;
    logic [4:0]             idx_q, idx_d;
    logic                   done_q, done_d;
    logic [7:0]             hex_char;
    logic                   accept;

    md5_hex_ascii #(.UPPERCASE(UPPERCASE)) u_hex (
        .nibble(hash_q[{idx_q, 2'b00} +: 4]),
        .ascii (hex_char)
    );

    assign accept = bus.tx_valid && bus.tx_ready;

    always_comb begin
        state_d = state_q;
        hash_d  = hash_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (bus.hash_valid) begin
                state_d = SEND;
                hash_d  = bus.hash;
                idx_d   = 5'd0;
            end
            SEND: if (accept) begin
                idx_d = idx_q == 5'(DIGEST_CHARS - 1) ? 5'd0 : idx_q + 5'd1;
                if (idx_q == 5'(DIGEST_CHARS - 1)) begin
`ifdef MD5_SER_CRLF_EN
                    state_d = CR;
`else
                    state_d = IDLE;
                    done_d  = 1'b1;
`endif
                end
            end
`ifdef MD5_SER_CRLF_EN
            CR: if (accept) state_d = LF;
            LF: if (accept) begin
                state_d = IDLE;
                done_d  = 1'b1;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            hash_q  <= '0;
            idx_q   <= 5'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hash_q  <= hash_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    assign bus.hash_ready = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.tx_valid   = state_q != IDLE;
    assign bus.done       = done_q;
    assign bus.tx_data    = state_q == SEND ? hex_char :
`ifdef MD5_SER_CRLF_EN
                            state_q == CR ? ASCII_CR : state_q == LF ? ASCII_LF :
`endif
                            8'h00;
endmodule
